// File: rtl/mio_bus_ctrl.sv
// Memory/IO bus controller: accepts one CPU access at a time and decodes it to RAM, IO or error.
// It inserts per-region wait states and completes each access with a one-cycle mio_ready pulse.
module mio_bus_ctrl #(
    parameter int unsigned RAM_AW   = 10,
    parameter int unsigned RAM_WAIT = 1,
    parameter int unsigned IO_WAIT  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_mio,
    input  logic              mem_r,
    input  logic              mem_w,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              mio_ready,
    output logic              bus_err,
    output logic              ram_en,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic              io_rd,
    output logic              io_wr,
    output logic [31:0]       io_addr,
    output logic [31:0]       io_wdata,
    input  logic [31:0]       io_rdata
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RAM_ACC = 2'd1;
    localparam logic [1:0] IO_ACC  = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        wr_q, wr_d;
    logic        err_q, err_d;
    logic        first_q, first_d;

    logic is_ram, is_io, bad_req;

    assign is_ram  = (addr[31:28] == 4'h0);
    assign is_io   = (addr[31:28] == 4'hE) || (addr[31:28] == 4'hF);
    assign bad_req = (mem_r & mem_w) || (addr[1:0] != 2'b00) || !(is_ram || is_io);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        wr_d    = wr_q;
        err_d   = err_q;
        first_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_mio && (mem_r || mem_w)) begin
                    addr_d  = addr;
                    wdata_d = wdata;
                    wr_d    = mem_w & ~mem_r;
                    err_d   = bad_req;
                    first_d = 1'b1;
                    if (bad_req) begin
                        // Rejected accesses never touch a strobe; reads return zero.
                        state_d = DONE;
                        if (mem_r) rdata_d = 32'h0;
                    end else if (is_ram) begin
                        state_d = RAM_ACC;
                        cnt_d   = 4'(RAM_WAIT);
                    end else begin
                        state_d = IO_ACC;
                        cnt_d   = 4'(IO_WAIT);
                    end
                end
            end
            RAM_ACC, IO_ACC: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = DONE;
                    if (!wr_q) rdata_d = (state_q == RAM_ACC) ? ram_rdata : io_rdata;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            first_q <= first_d;
        end
    end

    // All outputs decode registered state only.
    assign rdata     = rdata_q;
    assign mio_ready = (state_q == DONE);
    assign bus_err   = (state_q == DONE) & err_q;
    assign ram_en    = (state_q == RAM_ACC);
    assign ram_we    = (state_q == RAM_ACC) & wr_q;
    assign ram_addr  = addr_q[RAM_AW+1:2];
    assign ram_wdata = wdata_q;
    assign io_rd     = (state_q == IO_ACC) & ~wr_q;
    assign io_wr     = (state_q == IO_ACC) & wr_q & first_q;
    assign io_addr   = addr_q;
    assign io_wdata  = wdata_q;

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// Scoreboard bench for mio_bus_ctrl: stimulus pushes expected completions, a monitor pops them
// on each mio_ready and also tallies strobe activity for per-access checks.
module tb_mio_bus_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_mio, mem_r, mem_w;
    logic [31:0] addr, wdata, rdata;
    logic        mio_ready, bus_err, ram_en, ram_we;
    logic [9:0]  ram_addr;
    logic [31:0] ram_wdata, ram_rdata;
    logic        io_rd, io_wr;
    logic [31:0] io_addr, io_wdata, io_rdata;

    mio_bus_ctrl #(.RAM_AW(10), .RAM_WAIT(1), .IO_WAIT(2)) dut (
        .clk(clk), .reset(reset), .cpu_mio(cpu_mio), .mem_r(mem_r), .mem_w(mem_w),
        .addr(addr), .wdata(wdata), .rdata(rdata), .mio_ready(mio_ready), .bus_err(bus_err),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .io_rd(io_rd), .io_wr(io_wr), .io_addr(io_addr),
        .io_wdata(io_wdata), .io_rdata(io_rdata)
    );

    always #5 clk = ~clk;

    // Simple memories: data derived from the address so reads are hand-predictable.
    assign ram_rdata = 32'hC0DE_0000 | {22'h0, ram_addr};
    assign io_rdata  = io_addr ^ 32'h5A5A_5A5A;

    typedef struct {
        int          cyc;
        logic        err;
        logic        chk_rd;
        logic [31:0] rd;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          ready_count = 0;
    int          n_ram_en = 0, n_ram_we = 0, n_io_rd = 0, n_io_wr = 0;
    logic [31:0] last_io_wdata = 32'h0, last_io_addr = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (ram_en) n_ram_en <= n_ram_en + 1;
            if (ram_we) n_ram_we <= n_ram_we + 1;
            if (io_rd)  n_io_rd  <= n_io_rd + 1;
            if (io_wr) begin
                n_io_wr       <= n_io_wr + 1;
                last_io_wdata <= io_wdata;
                last_io_addr  <= io_addr;
            end
            if (bus_err && !mio_ready) chk("bus_err_without_ready", 32'(bus_err), 32'h0);
            if (mio_ready) begin
                ready_count <= ready_count + 1;
                if (sb.size() == 0) begin
                    chk("unexpected_ready", 32'(mio_ready), 32'h0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("ready_cycle", 32'(cyc), 32'(e.cyc));
                    chk("bus_err", 32'(bus_err), 32'(e.err));
                    if (e.chk_rd) chk("rdata", rdata, e.rd);
                end
            end
        end
    end

    task automatic drive(input logic m, input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d);
        cpu_mio = m; mem_r = r; mem_w = w; addr = a; wdata = d;
    endtask

    task automatic wait_ready(input int start_rc, input string name);
        for (int i = 0; i < 40 && ready_count == start_rc; i++) @(posedge clk);
        if (ready_count == start_rc) chk({name, "_timeout"}, 32'h0, 32'h1);
        #1;
    endtask

    // One access: lat is cycles from request to mio_ready; e_* are expected strobe-cycle counts.
    task automatic access(input string name, input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input int lat, input logic e_err,
                          input logic chk_rd, input logic [31:0] e_rd, input int e_ram_en,
                          input int e_ram_we, input int e_io_rd, input int e_io_wr);
        int s_en, s_we, s_rd, s_wr, rc;
        @(posedge clk); #1;
        s_en = n_ram_en; s_we = n_ram_we; s_rd = n_io_rd; s_wr = n_io_wr; rc = ready_count;
        drive(1'b1, r, w, a, d);
        sb.push_back('{cyc: cyc + lat, err: e_err, chk_rd: chk_rd, rd: e_rd});
        wait_ready(rc, name);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk({name, "_ram_en_cycles"}, 32'(n_ram_en - s_en), 32'(e_ram_en));
        chk({name, "_ram_we_cycles"}, 32'(n_ram_we - s_we), 32'(e_ram_we));
        chk({name, "_io_rd_cycles"}, 32'(n_io_rd - s_rd), 32'(e_io_rd));
        chk({name, "_io_wr_cycles"}, 32'(n_io_wr - s_wr), 32'(e_io_wr));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n, rc;
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk("reset_rdata", rdata, 32'h0);
        chk("reset_ready", 32'(mio_ready), 32'h0);
        chk("reset_strobes", {28'h0, ram_en, ram_we, io_rd, io_wr}, 32'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // RAM read / write, IO write / read
        access("ram_rd", 1, 0, 32'h0000_0010, 32'h0, 3, 0, 1, 32'hC0DE_0004, 2, 0, 0, 0);
        access("ram_wr", 0, 1, 32'h0000_0020, 32'h1234_5678, 3, 0, 1, 32'hC0DE_0004, 2, 2, 0, 0);
        access("io_wr", 0, 1, 32'hE000_0004, 32'hA5A5_0F0F, 4, 0, 1, 32'hC0DE_0004, 0, 0, 0, 1);
        chk("io_wdata", last_io_wdata, 32'hA5A5_0F0F);
        chk("io_addr", last_io_addr, 32'hE000_0004);
        access("io_rd", 1, 0, 32'hF000_0010, 32'h0, 4, 0, 1, 32'hAA5A_5A4A, 0, 0, 3, 0);

        // Errors
        access("unmapped_wr", 0, 1, 32'h4000_0000, 32'hDEAD_BEEF, 1, 1, 1, 32'hAA5A_5A4A,
               0, 0, 0, 0);
        access("misaligned_rd", 1, 0, 32'h0000_0002, 32'h0, 1, 1, 1, 32'h0, 0, 0, 0, 0);
        access("rw_both", 1, 1, 32'h0000_0010, 32'h0, 1, 1, 0, 32'h0, 0, 0, 0, 0);

        // Back-to-back with request held: second accepted the cycle after DONE
        @(posedge clk); #1;
        n = cyc; rc = ready_count;
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0);
        sb.push_back('{cyc: n + 3, err: 1'b0, chk_rd: 1'b1, rd: 32'hC0DE_0040});
        sb.push_back('{cyc: n + 7, err: 1'b0, chk_rd: 1'b1, rd: 32'hC0DE_03FF});
        wait_ready(rc, "b2b_first");
        addr = 32'h0000_0FFC;
        wait_ready(rc + 1, "b2b_second");
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Reset mid IO read: strobes drop, no ready, then a normal read
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 1'b0, 32'hE000_0008, 32'h0);
        @(posedge clk); #1;
        chk("io_rd_before_reset", 32'(io_rd), 32'h1);
        @(posedge clk); #1;
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        chk("io_rd_in_reset", 32'(io_rd), 32'h0);
        chk("rdata_in_reset", rdata, 32'h0);
        chk("ready_in_reset", 32'(mio_ready), 32'h0);
        @(posedge clk); #1 reset = 1'b0;
        repeat (4) @(posedge clk);
        access("post_reset_rd", 1, 0, 32'hE000_0008, 32'h0, 4, 0, 1, 32'hBA5A_5A52, 0, 0, 3, 0);

        // cpu_mio low: request ignored
        rc = ready_count;
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
        repeat (6) @(posedge clk);
        #1;
        chk("no_mio_no_ready", 32'(ready_count), 32'(rc));
        chk("no_mio_no_ram_en", 32'(ram_en), 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Address change mid RAM_ACC is ignored
        @(posedge clk); #1;
        n = cyc; rc = ready_count;
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0008, 32'h0);
        sb.push_back('{cyc: n + 3, err: 1'b0, chk_rd: 1'b1, rd: 32'hC0DE_0002});
        @(posedge clk); #1;
        addr = 32'h0000_0030;
        chk("ram_addr_acc1", 32'(ram_addr), 32'h2);
        @(posedge clk); #1;
        chk("ram_addr_acc2", 32'(ram_addr), 32'h2);
        wait_ready(rc, "addr_change");
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        repeat (3) @(posedge clk);
        if (sb.size() != 0) chk("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
